// File: rtl/eprisc_mem_arbiter.sv
`timescale 1ns/1ps
// Purpose: shares one single-port synchronous RAM between fetch (read-only) and load/store ports.
// Latency: read request edge to valid pulse is 2 cycles (3-cycle cadence); write takes 2-cycle cadence.
// Backpressure: a requester holds its request until its one-cycle ack; unacked requests simply wait.
//
// Ports:
//   iClk, iRst            clock, asynchronous active-high reset
//   iFReq/iFAddr          fetch request and address; oFAck accept pulse; oFData/oFValid read return
//   iDReq/iDWrite/iDAddr/iDData  data request; oDAck accept pulse; oDData/oDValid read return
//   oMemAddr, bMemData, oMemWrite, oMemEnable   RAM address, bidirectional data, strobes
//
// Build option: define EPRISC_ARB_ROUNDROBIN_EN for round-robin arbitration of contested cycles;
// otherwise the data port has fixed priority.

module eprisc_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iFReq,
    input  logic [ADDR_W-1:0] iFAddr,
    output logic              oFAck,
    output logic [DATA_W-1:0] oFData,
    output logic              oFValid,
    input  logic              iDReq,
    input  logic              iDWrite,
    input  logic [ADDR_W-1:0] iDAddr,
    input  logic [DATA_W-1:0] iDData,
    output logic              oDAck,
    output logic [DATA_W-1:0] oDData,
    output logic              oDValid,
    output logic [ADDR_W-1:0] oMemAddr,
    inout  wire  [DATA_W-1:0] bMemData,
    output logic              oMemWrite,
    output logic              oMemEnable
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t              state_q, state_d;
    logic                gport_q, gport_d;
    logic [ADDR_W-1:0]   gaddr_q, gaddr_d;
    logic                gwrite_q, gwrite_d;
    logic [DATA_W-1:0]   gdata_q, gdata_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic [DATA_W-1:0]   ddata_q, ddata_d;
    logic                fvalid_q, fvalid_d;
    logic                dvalid_q, dvalid_d;

    logic                any_req;
    logic                pick_data;
    logic                drive_en;

    assign any_req = iFReq | iDReq;

    // Winner selection. Only meaningful when sampled in IDLE with a request present.
`ifdef EPRISC_ARB_ROUNDROBIN_EN
    // 1 = data port is favoured on the next contested cycle.
    logic prio_q, prio_d;

    always_comb begin
        pick_data = iDReq & (~iFReq | prio_q);
        prio_d    = prio_q;
        // Only contested grants move the pointer, and it always points at the loser.
        if (state_q == ST_IDLE && iFReq && iDReq) begin
            prio_d = ~pick_data;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            prio_q <= 1'b1;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority: any data request beats a fetch request.
    always_comb begin
        pick_data = iDReq;
    end
`endif

    // State register and all datapath flops.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            gport_q  <= PORT_D;
            gaddr_q  <= '0;
            gwrite_q <= 1'b0;
            gdata_q  <= '0;
            fdata_q  <= '0;
            ddata_q  <= '0;
            fvalid_q <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gport_q  <= gport_d;
            gaddr_q  <= gaddr_d;
            gwrite_q <= gwrite_d;
            gdata_q  <= gdata_d;
            fdata_q  <= fdata_d;
            ddata_q  <= ddata_d;
            fvalid_q <= fvalid_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = any_req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = gwrite_q ? ST_IDLE : ST_RDATA;
            ST_RDATA:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant capture and read-return datapath.
    always_comb begin
        gport_d  = gport_q;
        gaddr_d  = gaddr_q;
        gwrite_d = gwrite_q;
        gdata_d  = gdata_q;
        fdata_d  = fdata_q;
        ddata_d  = ddata_q;
        fvalid_d = 1'b0;
        dvalid_d = 1'b0;

        if (state_q == ST_IDLE && any_req) begin
            gport_d  = pick_data ? PORT_D : PORT_F;
            gaddr_d  = pick_data ? iDAddr : iFAddr;
            gwrite_d = pick_data & iDWrite;
            if (pick_data) begin
                gdata_d = iDData;
            end
        end

        // RAM output was registered at the end of ACCESS; it is stable on the bus all of RDATA.
        if (state_q == ST_RDATA) begin
            if (gport_q == PORT_D) begin
                ddata_d  = bMemData;
                dvalid_d = 1'b1;
            end else begin
                fdata_d  = bMemData;
                fvalid_d = 1'b1;
            end
        end
    end

    // Output decode.
    always_comb begin
        oFAck      = (state_q == ST_ACCESS) && (gport_q == PORT_F);
        oDAck      = (state_q == ST_ACCESS) && (gport_q == PORT_D);
        oMemWrite  = (state_q == ST_ACCESS) && gwrite_q;
        oMemEnable = (state_q != ST_IDLE);
        // Drive the bus only while the write strobe is up, so RAM read drive never overlaps ours.
        drive_en   = (state_q == ST_ACCESS) && gwrite_q;
    end

    assign bMemData = drive_en ? gdata_q : {DATA_W{1'bz}};
    assign oMemAddr = gaddr_q;
    assign oFData   = fdata_q;
    assign oDData   = ddata_q;
    assign oFValid  = fvalid_q;
    assign oDValid  = dvalid_q;

endmodule

// File: tb/tb_eprisc_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for eprisc_mem_arbiter with a behavioural single-port synchronous RAM.
// Inputs are driven and outputs checked on the falling edge; a monitor samples 2 ns after each rising edge.
// Expected values are hand-computed per scenario; bus/ack rules are tallied by the monitor.

module tb_eprisc_mem_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iFReq;
    logic [7:0]  iFAddr;
    logic        oFAck;
    logic [31:0] oFData;
    logic        oFValid;
    logic        iDReq;
    logic        iDWrite;
    logic [7:0]  iDAddr;
    logic [31:0] iDData;
    logic        oDAck;
    logic [31:0] oDData;
    logic        oDValid;
    logic [7:0]  oMemAddr;
    wire  [31:0] mem_bus;
    logic        oMemWrite;
    logic        oMemEnable;

    eprisc_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iFReq      (iFReq),
        .iFAddr     (iFAddr),
        .oFAck      (oFAck),
        .oFData     (oFData),
        .oFValid    (oFValid),
        .iDReq      (iDReq),
        .iDWrite    (iDWrite),
        .iDAddr     (iDAddr),
        .iDData     (iDData),
        .oDAck      (oDAck),
        .oDData     (oDData),
        .oDValid    (oDValid),
        .oMemAddr   (oMemAddr),
        .bMemData   (mem_bus),
        .oMemWrite  (oMemWrite),
        .oMemEnable (oMemEnable)
    );

    always #5 iClk = ~iClk;

    // Behavioural RAM: registered read, drives the bus whenever enabled and not writing.
    logic [31:0] ram [0:255];
    logic [31:0] ram_q = 32'h0;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_dat;

    always @(posedge iClk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_dat;
        end else if (oMemEnable) begin
            if (oMemWrite) ram[oMemAddr] <= mem_bus;
            else           ram_q <= ram[oMemAddr];
        end
    end

    assign mem_bus = (oMemEnable && !oMemWrite) ? ram_q : 32'bz;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: event counters and per-cycle bus / ack rules.
    int          viol = 0;
    int          f_acks = 0, d_acks = 0, f_vals = 0, d_vals = 0;
    logic [7:0]  grant_seq = 8'h0;
    logic [31:0] exp_wdata = 32'h0;

    always begin
        @(posedge iClk);
        #2;
        if (!iRst) begin
            if (oFAck && oDAck) viol++;
            if (oMemWrite && !(oDAck && oMemEnable)) viol++;
            if (oMemWrite && mem_bus !== exp_wdata) viol++;
            if (oMemEnable && !oMemWrite && mem_bus !== ram_q) viol++;
            if (oFAck) f_acks++;
            if (oDAck) d_acks++;
            if (oFValid) f_vals++;
            if (oDValid) d_vals++;
            if (oFAck || oDAck) grant_seq = {grant_seq[6:0], oFAck};
        end
    end

    task automatic ram_load(input logic [7:0] a, input logic [31:0] d);
        @(negedge iClk);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        @(negedge iClk);
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1);
    end

    initial begin
        int d0, f0, dv0, fv0;
        iRst = 1'b1;
        iFReq = 1'b0; iFAddr = 8'h0;
        iDReq = 1'b0; iDWrite = 1'b0; iDAddr = 8'h0; iDData = 32'h0;
        ld_en = 1'b0; ld_addr = 8'h0; ld_dat = 32'h0;

        // Reset state
        repeat (2) @(negedge iClk);
        chk("rst_strobes", {oFAck, oDAck, oFValid, oDValid, oMemWrite, oMemEnable}, 6'b0);
        chk("rst_fdata", oFData, 32'h0);
        chk("rst_ddata", oDData, 32'h0);
        chk("rst_memaddr", oMemAddr, 8'h0);

        ram_load(8'h00, 32'h24412345);
        ram_load(8'h10, 32'hA5A50010);
        @(negedge iClk);
        iRst = 1'b0;

        // Fetch read of 0x00
        iFReq = 1'b1; iFAddr = 8'h00;
        @(negedge iClk);                     // ACCESS
        chk("f_ack", {oFAck, oDAck, oMemEnable, oMemWrite}, 4'b1010);
        chk("f_addr", oMemAddr, 8'h00);
        @(negedge iClk);                     // RDATA
        iFReq = 1'b0;
        chk("f_rdata_phase", {oFAck, oFValid, oMemEnable, oMemWrite}, 4'b0010);
        @(negedge iClk);                     // valid cycle
        chk("f_valid", {oFValid, oDValid}, 2'b10);
        chk("f_data", oFData, 32'h24412345);
        chk("f_idle_en", oMemEnable, 1'b0);
        @(negedge iClk);
        chk("f_valid_pulse", oFValid, 1'b0);

        // Data write 0xDEADBEEF to 0x05
        exp_wdata = 32'hDEADBEEF;
        iDReq = 1'b1; iDWrite = 1'b1; iDAddr = 8'h05; iDData = 32'hDEADBEEF;
        @(negedge iClk);                     // ACCESS
        chk("w_ack", {oDAck, oFAck, oMemWrite, oMemEnable}, 4'b1011);
        chk("w_bus", mem_bus, 32'hDEADBEEF);
        chk("w_addr", oMemAddr, 8'h05);
        @(negedge iClk);                     // back in IDLE
        iDReq = 1'b0; iDWrite = 1'b0;
        chk("w_done", {oDAck, oMemWrite, oMemEnable}, 3'b000);
        chk("w_ram", ram[5], 32'hDEADBEEF);

        // Data read of 0x05
        iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 8'h05;
        @(negedge iClk);
        chk("r_ack", {oDAck, oMemWrite, oMemEnable}, 3'b101);
        @(negedge iClk);
        iDReq = 1'b0;
        chk("r_rdata_phase", {oDAck, oDValid}, 2'b00);
        @(negedge iClk);
        chk("r_valid", {oDValid, oFValid}, 2'b10);
        chk("r_data", oDData, 32'hDEADBEEF);
        chk("r_fdata_hold", oFData, 32'h24412345);
        @(negedge iClk);
        chk("r_valid_pulse", oDValid, 1'b0);

        // Back-to-back writes with iDReq held: one ack every 2 cycles
        iDReq = 1'b1; iDWrite = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            iDAddr = 8'(i);
            iDData = 32'hC0DE0000 | 32'(i);
            exp_wdata = iDData;
            @(negedge iClk);
            chk("b2b_ack", oDAck, 1'b1);
            @(negedge iClk);
            chk("b2b_gap", oDAck, 1'b0);
        end
        iDReq = 1'b0; iDWrite = 1'b0;
        @(negedge iClk);
        for (int i = 1; i <= 4; i++) begin
            chk("b2b_ram", ram[i], 32'hC0DE0000 | 32'(i));
        end

        // Contention: both ports reading for 12 cycles
        d0 = d_acks; f0 = f_acks; dv0 = d_vals;
        iFReq = 1'b1; iFAddr = 8'h00;
        iDReq = 1'b1; iDWrite = 1'b0; iDAddr = 8'h05;
        repeat (12) @(negedge iClk);
        iFReq = 1'b0; iDReq = 1'b0;
        repeat (3) @(negedge iClk);
`ifdef EPRISC_ARB_ROUNDROBIN_EN
        chk("cont_d_grants", d_acks - d0, 2);
        chk("cont_f_grants", f_acks - f0, 2);
        chk("cont_order", grant_seq[3:0], 4'b0101);
        chk("cont_d_valids", d_vals - dv0, 2);
`else
        chk("cont_d_grants", d_acks - d0, 4);
        chk("cont_f_grants", f_acks - f0, 0);
        chk("cont_order", grant_seq[3:0], 4'b0000);
        chk("cont_d_valids", d_vals - dv0, 4);
`endif
        chk("cont_ddata", oDData, 32'hDEADBEEF);
        chk("cont_fdata", oFData, 32'h24412345);

        // Reset during RDATA of a fetch at 0x10
        iFReq = 1'b1; iFAddr = 8'h10;
        @(negedge iClk);
        chk("mr_ack", oFAck, 1'b1);
        @(negedge iClk);                     // RDATA
        iFReq = 1'b0;
        chk("mr_in_rdata", {oMemEnable, oFAck}, 2'b10);
        fv0 = f_vals;
        iRst = 1'b1;
        #1;
        chk("mr_strobes", {oFAck, oDAck, oFValid, oDValid, oMemWrite, oMemEnable}, 6'b0);
        chk("mr_memaddr", oMemAddr, 8'h00);
        chk("mr_fdata", oFData, 32'h0);
        chk("mr_ddata", oDData, 32'h0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        repeat (4) @(negedge iClk);
        chk("mr_no_valid", f_vals - fv0, 0);
        chk("mr_idle", {oMemEnable, oFData}, 33'h0);

        chk("bus_and_ack_rules", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
